// File: rtl/pixel_stream_buffer.sv
// Elastic pixel FIFO between the ray-trace pipeline and the VGA scan-out.
// Locks the stream to VGA frames via the in_sof marker; flushes and relocks after underflow or misalignment.
module pixel_stream_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter logic [7:0]  FILL_COLOR = 8'hE0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          video_active,
  input  logic          frame_sync,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_rgb,
  input  logic          in_sof,
  output logic [2:0]    pixel_r,
  output logic [2:0]    pixel_g,
  output logic [1:0]    pixel_b,
  output logic [AW:0]   fill_level,
  output logic [7:0]    err_count,
  output logic          locked
);

  typedef enum logic [1:0] {
    WAIT_SOF   = 2'd0,
    WAIT_FRAME = 2'd1,
    STREAM     = 2'd2
  } state_e;

  state_e      state_q;
  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  err_count_q, err_count_d;

  logic [8:0]  head;
  logic        empty;
  logic        full;
  logic        streaming;
  logic        visible_slot;
  logic        sof_match;
  logic        pop;
  logic        err;
  logic        push_req;
  logic        wr_en;
  logic [7:0]  pixel_word;

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign streaming = (state_q == STREAM) || ((state_q == WAIT_FRAME) && frame_sync);

  assign visible_slot = clk_en && video_active && streaming;
  assign sof_match    = (head[8] == frame_sync);
  assign pop          = visible_slot && !empty && sof_match;
  assign err          = visible_slot && (empty || !sof_match);

  // While hunting for a frame start the buffer swallows everything, so it never back-pressures.
  assign in_ready = (state_q == WAIT_SOF) ? 1'b1 : !full;
  assign push_req = in_valid && in_ready;
  assign wr_en    = push_req && !err && ((state_q != WAIT_SOF) || in_sof);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_count_d = err_count_q;
    if (err) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_SOF;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_count_q <= err_count_d;
      case (state_q)
        WAIT_SOF: begin
          if (push_req && in_sof) begin
            state_q <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (err) begin
            state_q <= WAIT_SOF;
          end else if (pop) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (err) begin
            state_q <= WAIT_SOF;
          end
        end
        default: state_q <= WAIT_SOF;
      endcase
    end
  end

  // Storage carries no reset; occupancy is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_sof, in_rgb};
    end
  end

  always_comb begin
    pixel_word = 8'h00;
    if (video_active) begin
      pixel_word = (streaming && !empty && sof_match) ? head[7:0] : FILL_COLOR;
    end
  end

  assign pixel_r    = pixel_word[7:5];
  assign pixel_g    = pixel_word[4:2];
  assign pixel_b    = pixel_word[1:0];
  assign fill_level = wr_ptr_q - rd_ptr_q;
  assign err_count  = err_count_q;
  assign locked     = (state_q == STREAM);

endmodule
